// File: rtl/memory_checker.sv
// Write-then-readback self-test over [START_ADDR, END_ADDR] of a single-outstanding memory port.
// Define MEM_CHECK_LFSR_EN for an LFSR data pattern; otherwise pattern = SEED ^ address.
module memory_checker #(
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 32,
  parameter int          START_ADDR = 0,
  parameter int          END_ADDR   = 1023,
  parameter logic [31:0] SEED       = 32'hA5A5_0001,
  parameter int          TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [15:0]           err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] END_A   = ADDR_WIDTH'(END_ADDR);
  localparam int                    TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]         TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, DONE} state_t;

  state_t                  state, state_nx;
  logic                    start_q, start_rise;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [TW-1:0]           tcnt;
  logic [DATA_WIDTH-1:0]   pattern, exp_data;
  logic                    run_init, addr_load, addr_step, latch_exp, rd_done, err_evt, to_evt;

`ifdef MEM_CHECK_LFSR_EN
  logic [31:0] lfsr;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  // The LFSR is pure datapath: it is always reloaded at the start of a pass.
  always_ff @(posedge clk) begin
    if (addr_load)      lfsr <= SEED;
    else if (addr_step) lfsr <= lfsr_next(lfsr);
  end

  assign pattern = lfsr[DATA_WIDTH-1:0];
`else
  function automatic logic [DATA_WIDTH-1:0] pattern_of(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] ext;
    ext = 32'(a);
    return SEED[DATA_WIDTH-1:0] ^ ext[DATA_WIDTH-1:0];
  endfunction

  assign pattern = pattern_of(addr);
`endif

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign start_rise = start & ~start_q;

  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    run_init  = 1'b0;
    addr_load = 1'b0;
    addr_step = 1'b0;
    latch_exp = 1'b0;
    rd_done   = 1'b0;
    err_evt   = 1'b0;
    to_evt    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_rise) begin
          run_init  = 1'b1;
          addr_load = 1'b1;
          state_nx  = WRITE;
        end
      end
      WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          if (addr == END_A) begin
            addr_load = 1'b1;
            state_nx  = RD_REQ;
          end else begin
            addr_step = 1'b1;
          end
        end
      end
      RD_REQ: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          latch_exp = 1'b1;
          state_nx  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // Data wins over a timeout landing in the same cycle.
        if (mem_rvalid) begin
          rd_done = 1'b1;
          err_evt = (mem_rdata != exp_data);
        end else if (tcnt == TO_LAST) begin
          rd_done = 1'b1;
          err_evt = 1'b1;
          to_evt  = 1'b1;
        end
        if (rd_done) begin
          if (addr == END_A) begin
            state_nx = DONE;
          end else begin
            addr_step = 1'b1;
            state_nx  = RD_REQ;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      start_q        <= 1'b0;
      addr           <= '0;
      tcnt           <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      timeout        <= 1'b0;
    end else begin
      state   <= state_nx;
      start_q <= start;
      if (addr_load)      addr <= START_A;
      else if (addr_step) addr <= addr + ADDR_WIDTH'(1);
      if (latch_exp)              tcnt <= '0;
      else if (state == RD_WAIT)  tcnt <= tcnt + TW'(1);
      if (run_init) begin
        err_cnt        <= '0;
        first_err_addr <= '0;
        timeout        <= 1'b0;
      end else if (err_evt) begin
        if (err_cnt == 16'd0) first_err_addr <= addr;
        err_cnt <= sat_inc(err_cnt);
        if (to_evt) timeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (latch_exp) exp_data <= pattern;
  end

  assign mem_addr  = addr;
  assign mem_wdata = (state == WRITE) ? pattern : '0;
  assign busy      = (state == WRITE) || (state == RD_REQ) || (state == RD_WAIT);
  assign done      = (state == DONE);
  assign pass      = done && (err_cnt == 16'd0);
  assign fail      = done && (err_cnt != 16'd0);

endmodule

// File: tb/tb_memory_checker.sv
// Scoreboard bench for memory_checker over a 16-word window with a small responsive memory model.
// Build with or without MEM_CHECK_LFSR_EN; the reference pattern follows the same macro.
module tb_memory_checker;
  localparam int          AW    = 16;
  localparam int          DW    = 32;
  localparam int          END_A = 15;
  localparam int          TO    = 8;
  localparam logic [31:0] SEED  = 32'hA5A5_0001;

  logic          clk = 1'b0;
  logic          rst, start;
  logic          mem_req, mem_we, mem_ready, mem_rvalid;
  logic [AW-1:0] mem_addr, first_err_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, done, pass, fail, timeout;
  logic [15:0]   err_cnt;

  memory_checker #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(0), .END_ADDR(END_A),
    .SEED(SEED), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } txn_t;
  typedef struct { logic ps; logic fl; logic to; logic [15:0] cnt; logic [AW-1:0] fea; } res_t;
  txn_t txq[$];
  res_t resq[$];

  function automatic logic [DW-1:0] pat(input int k);
`ifdef MEM_CHECK_LFSR_EN
    logic [31:0] s;
    s = SEED;
    for (int i = 0; i < k; i++) s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    return s;
`else
    return SEED ^ 32'(k);
`endif
  endfunction

  // Memory model: 2-cycle read latency, optional bit flips, ready toggling and a hung read at addr 3.
  bit          flip_en = 0, hang_en = 0, toggle_ready = 0;
  logic [DW-1:0] mem [0:END_A];
  logic        pend = 1'b0, hang = 1'b0, hang_used = 1'b0, rdy_t = 1'b0;
  logic [4:0]  dly = '0;
  logic [AW-1:0] raddr = '0;

  assign mem_ready = ~hang & (~toggle_ready | rdy_t);

  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  end

  always @(posedge clk) begin
    rdy_t      <= ~rdy_t;
    mem_rvalid <= 1'b0;
    if (!hang_en) hang_used <= 1'b0;
    if (pend) begin
      if (dly == 0) begin
        mem_rvalid <= 1'b1;
        if (hang)
          mem_rdata <= ~mem[raddr[3:0]];
        else
          mem_rdata <= mem[raddr[3:0]] ^ {31'b0, flip_en && (raddr == 5 || raddr == 9)};
        pend <= 1'b0;
        hang <= 1'b0;
      end else begin
        dly <= dly - 5'd1;
      end
    end
    if (mem_req && mem_ready) begin
      if (mem_we) begin
        mem[mem_addr[3:0]] <= mem_wdata;
      end else begin
        pend  <= 1'b1;
        raddr <= mem_addr;
        if (hang_en && !hang_used && mem_addr == 3) begin
          dly       <= 5'd20;
          hang      <= 1'b1;
          hang_used <= 1'b1;
        end else begin
          dly <= 5'd1;
        end
      end
    end
  end

  // Monitor: pops expected transactions on handshakes and expected results on done.
  logic          prev_stall = 1'b0, prev_done = 1'b0;
  logic [49:0]   prev_cmd = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall)
        check("stall_stable", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'(prev_cmd));
      if (mem_req && mem_ready) begin
        if (txq.size() == 0) begin
          check("unexpected_txn", 64'(mem_addr), 64'hFFFF_FFFF);
        end else begin
          txn_t t;
          t = txq.pop_front();
          check("txn_we_addr", 64'({mem_we, mem_addr}), 64'({t.we, t.addr}));
          if (t.we) check("txn_wdata", 64'(mem_wdata), 64'(t.wdata));
        end
      end
      if (done && !prev_done) begin
        if (resq.size() == 0) begin
          check("unexpected_done", 64'(done), 64'(0));
        end else begin
          res_t r;
          r = resq.pop_front();
          check("res_pass_fail_to", 64'({pass, fail, timeout}), 64'({r.ps, r.fl, r.to}));
          check("res_err_cnt", 64'(err_cnt), 64'(r.cnt));
          check("res_first_err_addr", 64'(first_err_addr), 64'(r.fea));
        end
      end
    end
    prev_stall = mem_req & ~mem_ready & ~rst;
    prev_cmd   = {mem_req, mem_we, mem_addr, mem_wdata};
    prev_done  = done & ~rst;
  end

  task automatic prep(input bit fl, input bit hg, input bit tg, input logic ps, input logic fa,
                      input logic to, input logic [15:0] cnt, input logic [AW-1:0] fea);
    res_t r;
    flip_en = fl;
    hang_en = hg;
    toggle_ready = tg;
    for (int k = 0; k <= END_A; k++) txq.push_back('{1'b1, AW'(k), pat(k)});
    for (int k = 0; k <= END_A; k++) txq.push_back('{1'b0, AW'(k), '0});
    r = '{ps, fa, to, cnt, fea};
    resq.push_back(r);
  endtask

  task automatic raise_start();
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check({name, "_done"}, 64'(seen), 64'(1));
    @(negedge clk);
    check({name, "_txq_empty"}, 64'(txq.size()), 64'(0));
    check({name, "_resq_empty"}, 64'(resq.size()), 64'(0));
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({mem_req, mem_we, mem_addr, mem_wdata, busy, done, pass, fail, timeout}), 64'(0));
    check("reset_results", 64'({err_cnt, first_err_addr}), 64'(0));

    // Run 1: start already high as reset releases counts as a rise.
    prep(0, 0, 0, 1'b1, 1'b0, 1'b0, 16'd0, '0);
    rst = 1'b0;
    #1 check("req_before_edge", 64'(mem_req), 64'(0));
    @(negedge clk);
    check("first_req_latency", 64'({mem_req, mem_we, mem_addr, busy}), 64'({1'b1, 1'b1, 16'd0, 1'b1}));
    wait_done("run_ideal");

    repeat (10) @(negedge clk);
    check("no_rerun_held_start", 64'({busy, done, pass}), 64'({1'b0, 1'b1, 1'b1}));

    // Run 2: bit 0 flipped on reads of addr 5 and 9.
    prep(1, 0, 0, 1'b0, 1'b1, 1'b0, 16'd2, 16'd5);
    raise_start();
    wait_done("run_flip");

    // Run 3: ready toggling; results of the failing run must clear on restart.
    prep(0, 0, 1, 1'b1, 1'b0, 1'b0, 16'd0, '0);
    raise_start();
    @(negedge clk);
    check("restart_clear", 64'({busy, done, fail, timeout, err_cnt}), 64'({1'b1, 1'b0, 1'b0, 1'b0, 16'd0}));
    wait_done("run_toggle");

    // Run 4: read of addr 3 hangs past TIMEOUT, late data arrives while the next read is stalled.
    prep(0, 1, 0, 1'b0, 1'b1, 1'b1, 16'd1, 16'd3);
    raise_start();
    wait_done("run_timeout");

    // Run 5: reset during the write of addr 7.
    hang_en = 0;
    prep(0, 0, 0, 1'b1, 1'b0, 1'b0, 16'd0, '0);
    raise_start();
    found = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (mem_req && mem_we && mem_addr == 16'd7) begin
        found = 1;
        break;
      end
    end
    check("reach_write7", 64'(found), 64'(1));
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("midrun_reset_outputs", 64'({mem_req, mem_we, mem_addr, mem_wdata, busy, done, pass, fail, timeout}), 64'(0));
    check("midrun_reset_results", 64'({err_cnt, first_err_addr}), 64'(0));
    txq.delete();
    resq.delete();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("no_run_without_rise", 64'({busy, mem_req}), 64'(0));

    // Run 6: fresh rise after reset.
    prep(0, 0, 0, 1'b1, 1'b0, 1'b0, 16'd0, '0);
    start = 1'b1;
    wait_done("run_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
